detect_ctrl: RTL and testbench
==============================

Name: detect_ctrl

Overview:
- Sequences the Detect substates (Detect.Quiet, Detect.Active) for the PCIe physical layer.
- Owns the 12 ms timer: drives its enable and consumes its interrupt.
- Handshakes with the PHY receiver-detect circuit.
- Reports to the LTSSM which lanes have a receiver present and when Polling may begin.

Parameters:
- NUM_LANES, 4, number of lanes; sets the width of all per-lane vectors.
- EIDLE_EXIT_EN, 1, when 1, electrical-idle exit on any lane ends Detect.Quiet early.

Ports:
- clk_i  input  1  clock, 200 MHz.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- start_i  input  1  level; high while the LTSSM is in Detect. Low forces the block to IDLE.
- rx_elec_idle_i  input  NUM_LANES  per-lane electrical idle (1 = idle).
- timer_en_o  output  1  enable to the timer. The timer clears its count while this is low.
- timer_irq_i  input  1  timer interrupt; 1-cycle pulse when the timeout count is reached.
- rxdet_req_o  output  1  receiver-detect request level.
- rxdet_done_i  input  1  1-cycle pulse; receiver detect complete.
- rxdet_present_i  input  NUM_LANES  detect result; valid only in the cycle rxdet_done_i is high.
- detect_done_o  output  1  1-cycle pulse on entry to POLLING.
- lanes_active_o  output  NUM_LANES  lanes with a receiver present; valid in POLLING.
- state_o  output  3  current state encoding.
- attempt_cnt_o  output  8  receiver-detect requests issued in this Detect episode.

Behaviour:
- Reset (rst_ni low), all outputs 0:
  - state = IDLE.
  - timer_en_o = 0, rxdet_req_o = 0, detect_done_o = 0.
  - lanes_active_o = 0, attempt_cnt_o = 0.
  - stored mask = 0.
- All outputs are registered.
- State encodings: IDLE=0, QUIET=1, ACT_REQ=2, ACT_WAIT=3, ACT_REQ2=4, POLLING=5.
- Encodings 6 and 7 are unreachable; if ever entered, go to IDLE.
- start_i low, from any state: next state IDLE.
  - timer_en_o and rxdet_req_o drop the same edge.
  - Any in-flight rxdet_done_i is ignored.
  - This rule has priority over every transition below.
- IDLE:
  - On start_i high, go to QUIET.
  - attempt_cnt_o and lanes_active_o clear to 0 on this transition.
- Timer gap rule:
  - In QUIET and ACT_WAIT, timer_en_o is 0 in the first cycle after entry and 1 from the second cycle on.
  - timer_en_o is 0 in every other state.
  - This guarantees at least one cleared-count cycle between intervals.
- QUIET:
  - timer_irq_i while timer_en_o = 1: go to ACT_REQ.
  - If EIDLE_EXIT_EN = 1 and rx_elec_idle_i is not all-ones: go to ACT_REQ.
  - If both occur in the same cycle, a single transition to ACT_REQ is taken.
  - timer_irq_i seen while timer_en_o = 0 is ignored.
- ACT_REQ and ACT_REQ2, entry:
  - rxdet_req_o rises on the entry edge.
  - attempt_cnt_o increments on entry, saturating at 255.
- ACT_REQ and ACT_REQ2, handshake:
  - rxdet_req_o is held high until rxdet_done_i is sampled high.
  - rxdet_req_o falls on the edge that leaves the state.
  - rxdet_present_i is sampled in the rxdet_done_i cycle.
  - rxdet_done_i arriving in the entry cycle itself is accepted.
- ACT_REQ on done:
  - present all-ones: go to POLLING; lanes_active_o = present.
  - present all-zero: go to QUIET.
  - Otherwise (partial): stored mask = present; go to ACT_WAIT.
- ACT_WAIT:
  - On timer_irq_i with timer_en_o = 1, go to ACT_REQ2.
  - rx_elec_idle_i is ignored.
- ACT_REQ2 on done:
  - present == stored mask: go to POLLING; lanes_active_o = stored mask.
  - Otherwise: go to QUIET. The stored mask is kept but unused.
- POLLING:
  - detect_done_o pulses high for exactly one cycle on entry.
  - lanes_active_o is held.
  - The block stays in POLLING until start_i goes low.
- A new Detect episode always starts from IDLE via start_i rising.

Test Plan:
- NUM_LANES=4, start_i=1, all lanes idle, irq pulse at cycle 300 → timer_en_o=0 on the first QUIET cycle, then 1. At irq+1: state_o=2, rxdet_req_o=1, attempt_cnt_o=1.
- In ACT_REQ, done with present=4'b1111 → next cycle state_o=5, detect_done_o high 1 cycle, lanes_active_o=4'b1111, rxdet_req_o=0.
- present=4'b0000 → QUIET with the timer gap cycle. Next irq → ACT_REQ, attempt_cnt_o=2.
- Partial present=4'b0011 → ACT_WAIT. After irq → ACT_REQ2 with attempt_cnt_o=2. Then:
  - second result 4'b0011 → POLLING, lanes_active_o=4'b0011;
  - second result 4'b0111 → QUIET.
- In QUIET with timer not expired, rx_elec_idle_i=4'b1011 → ACT_REQ next cycle. Repeat with EIDLE_EXIT_EN=0 → remains in QUIET until irq.
- Abort and reset cases:
  - start_i low while in ACT_REQ with rxdet_req_o=1 → next cycle state_o=0, rxdet_req_o=0, timer_en_o=0. A following done pulse has no effect.
  - rst_ni low mid-ACT_WAIT → all outputs 0 immediately (asynchronously).
  - 300 forced all-zero retries → attempt_cnt_o saturates at 255.

Source files
------------

// File: rtl/detect_ctrl.sv
// detect_ctrl: sequences Detect.Quiet / Detect.Active, owns the 12 ms timer
// enable, handshakes with the PHY receiver-detect circuit and reports the
// lanes that have a receiver present.
module detect_ctrl #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned EIDLE_EXIT_EN = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [NUM_LANES-1:0] rx_elec_idle_i,
    output logic                 timer_en_o,
    input  logic                 timer_irq_i,
    output logic                 rxdet_req_o,
    input  logic                 rxdet_done_i,
    input  logic [NUM_LANES-1:0] rxdet_present_i,
    output logic                 detect_done_o,
    output logic [NUM_LANES-1:0] lanes_active_o,
    output logic [2:0]           state_o,
    output logic [7:0]           attempt_cnt_o
);

    localparam int unsigned ATT_W   = 8;
    localparam logic [ATT_W-1:0] ATT_MAX = {ATT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUIET    = 3'd1,
        ST_ACT_REQ  = 3'd2,
        ST_ACT_WAIT = 3'd3,
        ST_ACT_REQ2 = 3'd4,
        ST_POLLING  = 3'd5
    } state_t;

    state_t               state;
    logic [NUM_LANES-1:0] mask;
    logic                 eidle_exit;
    logic                 irq_valid;
    logic                 present_all;
    logic                 present_none;
    logic [ATT_W-1:0]     attempt_next;

    // Decoded inputs shared by several states
    assign eidle_exit   = (EIDLE_EXIT_EN != 0) && !(&rx_elec_idle_i);
    assign irq_valid    = timer_irq_i && timer_en_o;
    assign present_all  = &rxdet_present_i;
    assign present_none = ~|rxdet_present_i;
    assign attempt_next = (attempt_cnt_o == ATT_MAX) ? ATT_MAX : attempt_cnt_o + ATT_W'(1);

    assign state_o = state;

    // Detect sequencer: state and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_IDLE;
            timer_en_o     <= 1'b0;
            rxdet_req_o    <= 1'b0;
            detect_done_o  <= 1'b0;
            lanes_active_o <= '0;
            attempt_cnt_o  <= '0;
            mask           <= '0;
        end else begin
            detect_done_o <= 1'b0;
            if (!start_i) begin
                // Leaving Detect wins over everything, including a pending done
                state       <= ST_IDLE;
                timer_en_o  <= 1'b0;
                rxdet_req_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state          <= ST_QUIET;
                        timer_en_o     <= 1'b0;
                        attempt_cnt_o  <= '0;
                        lanes_active_o <= '0;
                    end
                    ST_QUIET: begin
                        if (irq_valid || eidle_exit) begin
                            state         <= ST_ACT_REQ;
                            timer_en_o    <= 1'b0;
                            rxdet_req_o   <= 1'b1;
                            attempt_cnt_o <= attempt_next;
                        end else begin
                            // Count is held clear for the entry cycle, then runs
                            timer_en_o <= 1'b1;
                        end
                    end
                    ST_ACT_REQ: begin
                        if (rxdet_done_i) begin
                            rxdet_req_o <= 1'b0;
                            if (present_all) begin
                                state          <= ST_POLLING;
                                lanes_active_o <= rxdet_present_i;
                                detect_done_o  <= 1'b1;
                            end else if (present_none) begin
                                state <= ST_QUIET;
                            end else begin
                                mask  <= rxdet_present_i;
                                state <= ST_ACT_WAIT;
                            end
                        end
                    end
                    ST_ACT_WAIT: begin
                        if (irq_valid) begin
                            state         <= ST_ACT_REQ2;
                            timer_en_o    <= 1'b0;
                            rxdet_req_o   <= 1'b1;
                            attempt_cnt_o <= attempt_next;
                        end else begin
                            timer_en_o <= 1'b1;
                        end
                    end
                    ST_ACT_REQ2: begin
                        if (rxdet_done_i) begin
                            rxdet_req_o <= 1'b0;
                            if (rxdet_present_i == mask) begin
                                state          <= ST_POLLING;
                                lanes_active_o <= mask;
                                detect_done_o  <= 1'b1;
                            end else begin
                                state <= ST_QUIET;
                            end
                        end
                    end
                    ST_POLLING: begin
                        timer_en_o  <= 1'b0;
                        rxdet_req_o <= 1'b0;
                    end
                    default: begin
                        state       <= ST_IDLE;
                        timer_en_o  <= 1'b0;
                        rxdet_req_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_detect_ctrl.sv
// Directed bench for detect_ctrl with an expected-value scoreboard.
`timescale 1ns/1ps
module tb_detect_ctrl;

    localparam int unsigned NL = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NL-1:0] eidle;
    logic          irq;
    logic          done;
    logic [NL-1:0] present;

    logic          ten, req, dd;
    logic [NL-1:0] lanes;
    logic [2:0]    st;
    logic [7:0]    att;

    logic          ten0, req0, dd0;
    logic [NL-1:0] lanes0;
    logic [2:0]    st0;
    logic [7:0]    att0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int st; int ten; int req; int dd; int lanes; int att;
    } exp_t;
    exp_t sb_q[$];

    detect_ctrl #(.NUM_LANES(NL), .EIDLE_EXIT_EN(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx_elec_idle_i(eidle),
        .timer_en_o(ten), .timer_irq_i(irq), .rxdet_req_o(req),
        .rxdet_done_i(done), .rxdet_present_i(present), .detect_done_o(dd),
        .lanes_active_o(lanes), .state_o(st), .attempt_cnt_o(att)
    );

    detect_ctrl #(.NUM_LANES(NL), .EIDLE_EXIT_EN(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx_elec_idle_i(eidle),
        .timer_en_o(ten0), .timer_irq_i(irq), .rxdet_req_o(req0),
        .rxdet_done_i(done), .rxdet_present_i(present), .detect_done_o(dd0),
        .lanes_active_o(lanes0), .state_o(st0), .attempt_cnt_o(att0)
    );

    initial clk = 1'b0;
    always #2.5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        if (exp >= 0) begin
            checks++;
            assert (got === exp) else begin
                failures++;
                $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
            end
        end
    endtask

    task automatic push(input int s, input int t, input int r, input int d,
                        input int l, input int a);
        exp_t e;
        e.st = s; e.ten = t; e.req = r; e.dd = d; e.lanes = l; e.att = a;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s got=empty_queue exp=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".state"},    int'(st),    e.st);
            chk({tag, ".timer_en"}, int'(ten),   e.ten);
            chk({tag, ".req"},      int'(req),   e.req);
            chk({tag, ".done"},     int'(dd),    e.dd);
            chk({tag, ".lanes"},    int'(lanes), e.lanes);
            chk({tag, ".attempt"},  int'(att),   e.att);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expect s/t/r/d/l/a after the next edge, then compare
    task automatic expect_step(input string tag, input int s, input int t, input int r,
                               input int d, input int l, input int a);
        push(s, t, r, d, l, a);
        step();
        pop_check(tag);
    endtask

    // leave Detect and re-enter: lands in QUIET with cleared counters
    task automatic restart();
        start = 1'b0;
        step();
        start = 1'b1;
        expect_step("restart", 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; eidle = 4'hF; irq = 1'b0;
        done = 1'b0; present = 4'h0;
        #12;
        push(0, 0, 0, 0, 0, 0);
        pop_check("reset");
        chk("reset.dut0_state", int'(st0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Timer-expiry path to POLLING with all lanes present
        start = 1'b1;
        expect_step("quiet_entry", 1, 0, 0, 0, 0, 0);
        irq = 1'b1;
        expect_step("irq_ignored_gap", 1, 1, 0, 0, 0, 0);
        irq = 1'b0;
        repeat (8) step();
        push(1, 1, 0, 0, 0, 0);
        pop_check("quiet_hold");
        irq = 1'b1;
        expect_step("act_req_entry", 2, 0, 1, 0, 0, 1);
        irq = 1'b0;
        expect_step("req_held", 2, 0, 1, 0, 0, 1);
        done = 1'b1; present = 4'hF;
        expect_step("polling_entry", 5, 0, 0, 1, 15, 1);
        done = 1'b0;
        expect_step("polling_hold", 5, 0, 0, 0, 15, 1);

        // No receiver: back to QUIET, then a second attempt
        restart();
        expect_step("timer_run", 1, 1, 0, 0, 0, 0);
        irq = 1'b1;
        expect_step("req_first", 2, 0, 1, 0, 0, 1);
        irq = 1'b0;
        done = 1'b1; present = 4'h0;
        expect_step("zero_to_quiet", 1, 0, 0, 0, 0, 1);
        done = 1'b0;
        expect_step("quiet_gap_end", 1, 1, 0, 0, 0, 1);
        irq = 1'b1;
        expect_step("second_attempt", 2, 0, 1, 0, 0, 2);
        irq = 1'b0;

        // Partial result confirmed by the second detect
        restart();
        step();
        irq = 1'b1;
        expect_step("pa_req", 2, 0, 1, 0, 0, 1);
        irq = 1'b0;
        done = 1'b1; present = 4'h3;
        expect_step("act_wait_entry", 3, 0, 0, 0, 0, 1);
        done = 1'b0; eidle = 4'h0;
        expect_step("wait_eidle_ignored", 3, 1, 0, 0, 0, 1);
        eidle = 4'hF;
        irq = 1'b1;
        expect_step("act_req2_entry", 4, 0, 1, 0, 0, 2);
        irq = 1'b0;
        done = 1'b1; present = 4'h3;
        expect_step("req2_match", 5, 0, 0, 1, 3, 2);
        done = 1'b0;

        // Partial result not confirmed: back to QUIET
        restart();
        step();
        irq = 1'b1; step(); irq = 1'b0;
        done = 1'b1; present = 4'h3; step(); done = 1'b0;
        step();
        irq = 1'b1;
        expect_step("pb_req2", 4, 0, 1, 0, 0, 2);
        irq = 1'b0;
        done = 1'b1; present = 4'h7;
        expect_step("req2_mismatch", 1, 0, 0, 0, 0, 2);
        done = 1'b0;

        // Timer expiry and eidle exit together: single transition
        restart();
        step();
        irq = 1'b1; eidle = 4'hB;
        expect_step("irq_and_eidle", 2, 0, 1, 0, 0, 1);
        irq = 1'b0; eidle = 4'hF;

        // Abort while a request is outstanding; late done has no effect
        start = 1'b0;
        expect_step("abort", 0, 0, 0, 0, 0, 1);
        done = 1'b1; present = 4'hF;
        expect_step("done_after_abort", 0, 0, 0, 0, 0, 1);
        done = 1'b0;

        // Electrical-idle exit, enabled vs disabled instance
        start = 1'b1;
        expect_step("eidle_restart", 1, 0, 0, 0, 0, 0);
        step();
        eidle = 4'hB;
        expect_step("eidle_exit", 2, 0, 1, 0, 0, 1);
        chk("eidle_disabled.state", int'(st0), 1);
        repeat (3) step();
        chk("eidle_disabled_hold.state", int'(st0), 1);
        eidle = 4'hF;
        irq = 1'b1;
        expect_step("irq_in_act_req_ignored", 2, 0, 1, 0, 0, 1);
        chk("eidle_disabled_irq.state", int'(st0), 2);
        chk("eidle_disabled_irq.attempt", int'(att0), 1);
        irq = 1'b0;

        // Asynchronous reset in the middle of ACT_WAIT
        done = 1'b1; present = 4'h3;
        expect_step("wait_before_reset", 3, 0, 0, 0, 0, 1);
        done = 1'b0;
        step();
        #1 rst_n = 1'b0;
        #1;
        push(0, 0, 0, 0, 0, 0);
        pop_check("async_reset");
        chk("async_reset.dut0_state", int'(st0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back all-zero retries saturate the attempt counter
        expect_step("sat_quiet", 1, 0, 0, 0, 0, 0);
        eidle = 4'h0; done = 1'b1; present = 4'h0;
        repeat (20) step();
        push(1, 0, 0, 0, 0, 10);
        pop_check("retry_count");
        repeat (580) step();
        push(1, 0, 0, 0, 0, 255);
        pop_check("attempt_saturate");
        expect_step("saturate_hold", 2, 0, 1, 0, 0, 255);

        start = 1'b0; done = 1'b0; eidle = 4'hF;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
